// File: rtl/fir_decim_symmetric.sv
// Symmetric FIR decimator with a writable half-coefficient bank. One pre-adder and
// one multiplier-accumulator are shared across the tap pairs, one pair per cycle.
//
// Handshakes: a beat transfers on a rising edge where valid & ready are both high.
// valid never depends on ready, and data is held while valid is high and ready is low.
module fir_decim_symmetric #(
  parameter int TAPS      = 64,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15,
  parameter int DECIM     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       coef_we_i,
  input  logic [$clog2(TAPS/2)-1:0]  coef_addr_i,
  input  logic [COEF_W-1:0]          coef_data_i,
  output logic                       coef_err_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       sat_o,
  output logic [1:0]                 state_dbg_o
);

  localparam int HALF   = TAPS / 2;
  localparam int AW     = $clog2(HALF);
  localparam int IDX_W  = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + COEF_W + 1 + $clog2(TAPS / 2);
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(longint'(1) << (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(longint'(1) << (DATA_W - 1)));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_q    [TAPS];
  logic signed [COEF_W-1:0] coef_q [HALF];
  logic [PH_W-1:0]          phase_q;
  logic [AW-1:0]            k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        out_data_q;
  logic                     sat_q;
  logic                     coef_err_q;

  logic                     accept;
  logic                     trigger;
  logic                     last_pair;
  logic                     coef_wr_ok;
  logic                     coef_wr_bad;
  logic [IDX_W-1:0]         near_idx;
  logic [IDX_W-1:0]         far_idx;
  logic signed [PRE_W-1:0]  pre_sum;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  shifted;

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_OUT);
  assign out_data_o  = out_data_q;
  assign sat_o       = sat_q;
  assign coef_err_o  = coef_err_q;
  assign state_dbg_o = state_q;

  // A sample presented together with clear_i is discarded, not accepted.
  assign accept    = in_valid_i & in_ready_o & ~clear_i;
  assign trigger   = accept & (phase_q == PH_W'(DECIM - 1));
  assign last_pair = (k_q == AW'(HALF - 1));

  assign coef_wr_ok  = coef_we_i & ((state_q == S_IDLE) | (state_q == S_OUT));
  assign coef_wr_bad = coef_we_i & ((state_q == S_MAC) | (state_q == S_ROUND));

  // Pair k combines the k-th newest and k-th oldest samples; c[0] weights the outer pair.
  assign near_idx = IDX_W'(k_q);
  assign far_idx  = IDX_W'(TAPS - 1) - IDX_W'(k_q);
  assign pre_sum  = PRE_W'(x_q[near_idx]) + PRE_W'(x_q[far_idx]);
  assign prod     = PROD_W'(pre_sum) * PROD_W'(coef_q[k_q]);

  assign rnd_sum = acc_q + RND;
  assign shifted = rnd_sum >>> COEF_FRAC;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (trigger) state_d = S_MAC;
        S_MAC:   if (last_pair) state_d = S_ROUND;
        S_ROUND: state_d = S_OUT;
        S_OUT:   if (out_ready_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
      phase_q    <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
      phase_q <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
        x_q[0] <= in_data_i;
        if (phase_q == PH_W'(DECIM - 1)) phase_q <= '0;
        else                             phase_q <= phase_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        S_MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          k_q   <= k_q + 1'b1;
        end
        S_ROUND: begin
          if (shifted > SAT_MAX) begin
            out_data_q <= SAT_MAX[DATA_W-1:0];
            sat_q      <= 1'b1;
          end else if (shifted < SAT_MIN) begin
            out_data_q <= SAT_MIN[DATA_W-1:0];
            sat_q      <= 1'b1;
          end else begin
            out_data_q <= shifted[DATA_W-1:0];
            sat_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The bank survives clear_i; only rst_i wipes it and the sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < HALF; i++) coef_q[i] <= '0;
      coef_err_q <= 1'b0;
    end else begin
      if (coef_wr_ok)  coef_q[coef_addr_i] <= coef_data_i;
      if (coef_wr_bad) coef_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_decim_symmetric.sv
// Bench for fir_decim_symmetric: randomized and directed stimulus, a behavioural
// model of the filter equation, and a scoreboard queue drained by an output monitor.
module tb_fir_decim_symmetric;

  localparam int TAPS      = 64;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 15;
  localparam int DECIM     = 2;
  localparam int HALF      = TAPS / 2;
  localparam int AW        = $clog2(HALF);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              clear_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              coef_we_i;
  logic [AW-1:0]     coef_addr_i;
  logic [COEF_W-1:0] coef_data_i;
  logic              coef_err_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              sat_o;
  logic [1:0]        state_dbg_o;

  fir_decim_symmetric #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .DECIM(DECIM)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
    .coef_err_o(coef_err_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .sat_o(sat_o), .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] mon_e;
  int hist [TAPS];
  int coef_m [HALF];
  int phase_m;
  int checks = 0;
  int failures = 0;
  int n_out = 0;
  int last_out = 0;
  logic last_sat = 1'b0;
  int bp_mode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DATA_W:0] model_y();
    longint s;
    longint maxv;
    longint minv;
    logic [63:0] sv;
    logic sat;
    maxv = (longint'(1) << (DATA_W - 1)) - 1;
    minv = -(longint'(1) << (DATA_W - 1));
    s = 0;
    for (int k = 0; k < HALF; k++)
      s += longint'(coef_m[k]) * longint'(hist[k] + hist[TAPS-1-k]);
    s = (s + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
    sat = 1'b0;
    if (s > maxv) begin s = maxv; sat = 1'b1; end
    if (s < minv) begin s = minv; sat = 1'b1; end
    sv = s;
    return {sat, sv[DATA_W-1:0]};
  endfunction

  task automatic model_accept(input int v);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
    if (phase_m == DECIM - 1) begin
      phase_m = 0;
      exp_q.push_back(model_y());
    end else begin
      phase_m++;
    end
  endtask

  task automatic model_flush(input bit wipe_coefs);
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    phase_m = 0;
    if (wipe_coefs) for (int k = 0; k < HALF; k++) coef_m[k] = 0;
  endtask

  function automatic int rand_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ---------------- output-side drivers / monitor ----------------
  always begin
    @(negedge clk_i);
    #1;
    case (bp_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ($urandom_range(0, 3) != 0);
      default: out_ready_i = 1'b0;
    endcase
  end

  always begin
    @(negedge clk_i);
    #4;
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0d expected=none", $signed(out_data_o));
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", $signed(out_data_o), $signed(mon_e[DATA_W-1:0]));
        chk("out_sat", sat_o, mon_e[DATA_W]);
      end
      last_out = $signed(out_data_o);
      last_sat = sat_o;
      n_out++;
    end
  end

  // ---------------- input-side drivers (called at a falling edge) ----------------
  task automatic send(input int v);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i  = v[DATA_W-1:0];
    while (!in_ready_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) begin
      timeout_fail("send");
      in_valid_i = 1'b0;
      return;
    end
    model_accept(v);
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic send_until_trigger();
    int guard;
    guard = 0;
    while (exp_q.size() == 0 && guard < 2 * DECIM + 2) begin
      send(rand_s16());
      guard++;
    end
  endtask

  task automatic wr_coef(input int a, input int v, input bit upd);
    coef_we_i   = 1'b1;
    coef_addr_i = a[AW-1:0];
    coef_data_i = v[COEF_W-1:0];
    @(negedge clk_i);
    coef_we_i = 1'b0;
    if (upd) coef_m[a] = v;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready_o) && n < 4000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 4000) timeout_fail(name);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  int held;
  int n_before;
  bit stable;
  bit ready_low;
  int n;

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    coef_we_i = 1'b0; coef_addr_i = '0; coef_data_i = '0;
    out_ready_i = 1'b1;
    model_flush(1'b1);
    repeat (3) @(negedge clk_i);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_coef_err", coef_err_o, 0);
    chk("rst_state", state_dbg_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // impulse response walks the coefficient ramp out and back
    for (int k = 0; k < HALF; k++) wr_coef(k, 512 * (k + 1), 1'b1);
    send(32767);
    repeat (TAPS - 1) send(0);
    wait_drain("impulse_drain");
    chk("impulse_count", n_out, HALF);
    chk("impulse_last", last_out, 512);

    // DC gain
    for (int k = 0; k < HALF; k++) wr_coef(k, 1024, 1'b1);
    repeat (TAPS + 2) send(1000);
    wait_drain("dc_drain");
    chk("dc_out", last_out, 2000);
    chk("dc_sat", last_sat, 0);

    // random coefficients and data under random backpressure
    bp_mode = 1;
    for (int k = 0; k < HALF; k++) wr_coef(k, rand_s16() >>> ($urandom_range(0, 1) * 4), 1'b1);
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk_i);
      send(rand_s16());
    end
    wait_drain("random_drain");
    bp_mode = 0;

    // saturation both ways
    for (int k = 0; k < HALF; k++) wr_coef(k, 32767, 1'b1);
    repeat (TAPS) send(32767);
    wait_drain("satp_drain");
    chk("sat_pos_data", last_out, 32767);
    chk("sat_pos_flag", last_sat, 1);
    repeat (TAPS) send(-32768);
    wait_drain("satn_drain");
    chk("sat_neg_data", last_out, -32768);
    chk("sat_neg_flag", last_sat, 1);

    // backpressure hold
    for (int k = 0; k < HALF; k++) wr_coef(k, rand_s16(), 1'b1);
    bp_mode = 2;
    @(negedge clk_i);
    send_until_trigger();
    n = 0;
    while (!out_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) timeout_fail("bp_wait_valid");
    #2;
    held = out_data_o;
    in_valid_i = 1'b1;
    in_data_i  = 16'h1234;
    stable = 1'b1;
    ready_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #2;
      if (out_data_o != held[DATA_W-1:0] || !out_valid_o) stable = 1'b0;
      if (in_ready_o) ready_low = 1'b0;
    end
    chk("bp_data_stable", stable, 1);
    chk("bp_in_ready_low", ready_low, 1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    bp_mode = 0;
    @(negedge clk_i);
    #2;
    chk("bp_release_in_ready", in_ready_o, 1);
    chk("bp_release_out_valid", out_valid_o, 0);
    @(negedge clk_i);

    // coefficient write while busy is dropped
    repeat (TAPS) send(rand_s16());
    wait_drain("coef_fill_drain");
    send_until_trigger();
    wr_coef(0, 7, 1'b0);
    chk("coef_err_set", coef_err_o, 1);
    wait_drain("coef_busy_drain");
    repeat (2 * DECIM) send(rand_s16());
    wait_drain("coef_old_drain");
    wr_coef(0, 7, 1'b1);
    chk("coef_err_sticky", coef_err_o, 1);
    repeat (2 * DECIM) send(rand_s16());
    wait_drain("coef_new_drain");

    // clear mid-MAC drops the pending output and empties the delay line
    send_until_trigger();
    repeat (5) @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    void'(exp_q.pop_back());
    model_flush(1'b0);
    n_before = n_out;
    chk("clear_state", state_dbg_o, 0);
    chk("clear_out_valid", out_valid_o, 0);
    chk("clear_in_ready", in_ready_o, 1);
    repeat (40) @(negedge clk_i);
    chk("clear_no_output", n_out, n_before);
    in_valid_i = 1'b1;
    in_data_i  = 16'h4321;
    clear_i    = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    clear_i    = 1'b0;
    for (int i = 0; i < 2 * DECIM + 1; i++) send(rand_s16());
    wait_drain("clear_drain");
    chk("clear_coef_err_kept", coef_err_o, 1);

    // asynchronous reset between edges mid-MAC
    send_until_trigger();
    repeat (3) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_out_valid", out_valid_o, 0);
    chk("arst_in_ready", in_ready_o, 1);
    chk("arst_coef_err", coef_err_o, 0);
    exp_q.delete();
    model_flush(1'b1);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 10; i++) send(rand_s16());
    wait_drain("arst_drain");
    chk("arst_zero_out", last_out, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_decim_symmetric.md
# fir_decim_symmetric

Parametrised, runtime-programmable symmetric FIR decimator for the PDM-to-PCM path. It replaces the fixed compile-time coefficient set with a writable half-coefficient bank, and generalises tap count, data/coefficient widths and decimation factor. One time-shared pre-adder plus multiplier-accumulator computes each output. The block sits after the CIC stage and feeds PCM samples to the output formatter over a valid/ready handshake.

## Interface
- TAPS, 64: filter length; even, ≥4; TAPS/2 stored coefficients
- DATA_W, 16: signed input and output sample width
- COEF_W, 16: signed coefficient width
- COEF_FRAC, 15: coefficient fractional bits (Q1.15 default)
- DECIM, 2: decimation factor, ≥1
- ACC_W (localparam): DATA_W+COEF_W+1+$clog2(TAPS/2)
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous flush
- in_valid_i / in_ready_o  in/out  1  input handshake
- in_data_i  in  DATA_W  signed sample
- coef_we_i  in  1  coefficient write strobe
- coef_addr_i  in  $clog2(TAPS/2)  coefficient index k
- coef_data_i  in  COEF_W  signed coefficient
- coef_err_o  out  1  sticky: write dropped while busy
- out_valid_o / out_ready_i  out/in  1  output handshake
- out_data_o  out  DATA_W  signed filtered sample
- sat_o  out  1  current out_data_o was saturated

## Operation
- Delay line x[0..TAPS-1], x[0] newest. It shifts on each accepted input (in_valid_i & in_ready_o).
- Phase counter 0..DECIM-1 increments per accepted sample and wraps. An accept with phase==DECIM-1 triggers a computation.
- Output y = Σ_{k=0}^{TAPS/2-1} c[k]·(x[k]+x[TAPS-1-k]). c[0] weights the outermost pair.
- FSM states:
  - IDLE: in_ready_o=1. The triggering accept moves to MAC, with k=0 and acc=0.
  - MAC: one pair per cycle for TAPS/2 cycles. Go to ROUND after k=TAPS/2-1.
  - ROUND: apply the arithmetic rules below, register out_data_o and sat_o, set out_valid_o, then go to OUT.
  - OUT: hold until out_ready_i=1, then return to IDLE.
- in_ready_o=0 in MAC, ROUND and OUT. The delay line is frozen, so upstream stalls and no sample is lost.
- Arithmetic:
  - Pre-add is DATA_W+1 bits; product is DATA_W+1+COEF_W bits; the accumulator is ACC_W bits and cannot overflow.
  - Rounding: add 2^(COEF_FRAC-1), then arithmetic right shift by COEF_FRAC (round half up).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. sat_o=1 when clipping occurs.
- Coefficient bank is register-based, TAPS/2 entries.
  - Writes take effect in IDLE and OUT.
  - A write during MAC or ROUND is dropped and sets coef_err_o, which clears only on rst_i.
  - A new coefficient applies from the next computation.
- clear_i: zeroes the delay line, phase, acc and k. Aborts MAC/ROUND, drops any pending output, and returns to IDLE. The coefficient bank and coef_err_o are kept.
- Priority: rst_i > clear_i > handshakes > coefficient write.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, sat_o=0, coef_err_o=0. State is IDLE, phase 0, delay line and coefficients all zero.
- Latency: the triggering accept occurs at edge E0. MAC runs on edges E1..E(TAPS/2). ROUND registers the result at edge E(TAPS/2+1), and out_valid_o is high after that edge. The default is 33 cycles.
- out_data_o and sat_o are stable while out_valid_o=1 and out_ready_i=0.
- Output transfer completes on the edge where out_valid_o & out_ready_i. in_ready_o rises after that edge.
- Maximum throughput is one output per TAPS/2+2+DECIM cycles when out_ready_i is held at 1.
- rst_i mid-MAC: all outputs return to reset values immediately (asynchronous). No output is produced.
- clear_i in the same cycle as in_valid_i: the sample is not accepted.

## Test plan
- DC gain: defaults, all c[k]=1024, feed 64 samples of 1000 then continue with 1000 → the first output after the delay line is full is 2000; sat_o=0.
- Impulse: c[k]=512·(k+1). After reset, feed 32767 then zeros. Successive outputs equal (32767·512·(j+1)+16384)>>>15 for j=1,3,…,31,30,28,…,0, i.e. 1024, 2048, … ±0 LSB.
- Saturation:
  - all c[k]=32767, constant input 32767 → out_data_o=32767, sat_o=1
  - constant input -32768 → out_data_o=-32768, sat_o=1
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o → out_data_o is unchanged, in_ready_o=0, and no accepts occur. Release → transfer happens and in_ready_o=1 on the next cycle.
- Coefficient timing:
  - write c[0]=7 during MAC → dropped, coef_err_o=1
  - the same write in IDLE → affects the next output
  - clear_i mid-MAC → no output, state IDLE, delay line zeroed
- Async reset: assert rst_i mid-MAC, between clock edges → out_valid_o=0 and in_ready_o=1 before the next edge. Coefficients read back as zero by behaviour: output is 0 for any input.
